// File: rtl/conv_frame_sched.sv
// Frame sequencer for the 3x3 conv datapath: feeds one IMG_W x IMG_H frame,
// drains the pipeline, and issues capture enables with the (row, col) of each output.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; cnt held at 0
// S_FEED  | accepting pixels; cnt advances on each in_vld beat
// S_DRAIN | no input; cnt free-runs to flush the conv pipeline
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module conv_frame_sched #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int K        = 3,
  parameter int PIPE_LAT = 2,
  parameter int DRAIN    = 5,
  localparam int CNT_LAST = IMG_W*IMG_H + DRAIN - 1,
  localparam int CNT_W    = $clog2(CNT_LAST+1),
  localparam int ROW_W    = $clog2(IMG_H-K+1),
  localparam int COL_W    = $clog2(IMG_W-K+1),
  localparam int NUM_W    = $clog2((IMG_W-K+1)*(IMG_H-K+1)+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [CNT_W-1:0] cnt,
  output logic             step,
  output logic             cap_en,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic [NUM_W-1:0] out_num,
  output logic             busy,
  output logic             done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int N_OUT = OUT_W * OUT_H;
  localparam int OFF   = (K-1)*IMG_W + (K-1) + PIPE_LAT;

  localparam logic [CNT_W-1:0] OFF_C       = CNT_W'(OFF);
  localparam logic [CNT_W-1:0] IMG_W_C     = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] OUT_W_C     = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] OUT_H_C     = CNT_W'(OUT_H);
  localparam logic [CNT_W-1:0] FEED_LAST_C = CNT_W'(IMG_W*IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_C  = CNT_W'(CNT_LAST);
  localparam logic [COL_W-1:0] COL_LAST_C  = COL_W'(OUT_W - 1);
  localparam logic [NUM_W-1:0] NUM_MAX_C   = NUM_W'(N_OUT);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic             in_win;
  logic [CNT_W-1:0] rel;

  always_comb begin
    in_rdy = (state == S_FEED);
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    // abort wins over any advance, which also suppresses capture that cycle
    step   = ((state == S_FEED && in_vld) || state == S_DRAIN) && !abort;
    in_win = (cnt >= OFF_C);
    rel    = in_win ? (cnt - OFF_C) : '0;
    cap_en = step && in_win && ((rel % IMG_W_C) < OUT_W_C) && ((rel / IMG_W_C) < OUT_H_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      out_row <= '0;
      out_col <= '0;
      out_num <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FEED;
            cnt     <= '0;
            out_row <= '0;
            out_col <= '0;
            out_num <= '0;
          end
        end
        S_FEED: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (step) begin
            if (cnt == FEED_LAST_C) state <= S_DRAIN;
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST_C) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      // cap_en is only ever high in FEED/DRAIN, so this never collides with the IDLE clear
      if (cap_en) begin
        if (out_col == COL_LAST_C) begin
          out_col <= '0;
          out_row <= out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
        if (out_num != NUM_MAX_C) out_num <= out_num + NUM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sched.sv
// Directed bench for conv_frame_sched: continuous, stall, abort, ignored start,
// async reset and back-to-back frames, with hand-computed expectations.
module tb_conv_frame_sched;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_vld;
  logic       in_rdy, step, cap_en, busy, done;
  logic [6:0] cnt;
  logic [2:0] out_row, out_col;
  logic [5:0] out_num;

  conv_frame_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_vld(in_vld),
    .in_rdy(in_rdy), .cnt(cnt), .step(step), .cap_en(cap_en),
    .out_row(out_row), .out_col(out_col), .out_num(out_num),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int p;
  bit ok;

  int cap_cnt_q[$], cap_row_q[$], cap_col_q[$];
  int done_cyc_q[$], done_caps_q[$];
  int done_cnt, done_cyc, done_cntval, done_num, rdy_cnt, stray_cap;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // passive recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (cap_en) begin
      cap_cnt_q.push_back(int'(cnt));
      cap_row_q.push_back(int'(out_row));
      cap_col_q.push_back(int'(out_col));
      if (!busy) stray_cap++;
    end
    if (in_rdy) rdy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc    = cyc_n;
      done_cntval = int'(cnt);
      done_num    = int'(out_num);
      done_cyc_q.push_back(cyc_n);
      done_caps_q.push_back(cap_cnt_q.size());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    cap_cnt_q.delete(); cap_row_q.delete(); cap_col_q.delete();
    done_cyc_q.delete(); done_caps_q.delete();
    done_cnt = 0; done_cyc = 0; done_cntval = 0; done_num = 0;
    rdy_cnt = 0; stray_cap = 0;
  endtask

  task automatic begin_frame;
    clear_mon();
    start  = 1'b1;
    in_vld = 1'b1;
    tick();
    start = 1'b0;
    p = cyc_n;
  endtask

  task automatic wait_cnt(input int target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy && int'(cnt) == target) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done_cnt != 0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // captures must be row-major at cnt = 20 + 8*row + col for row, col in 0..5
  function automatic int cap_seq_errs();
    int errs = 0;
    if (cap_cnt_q.size() != 36) return 99;
    for (int i = 0; i < 36; i++) begin
      if (cap_cnt_q[i] != 20 + 8*(i/6) + (i%6)) errs++;
      if (cap_row_q[i] != i/6) errs++;
      if (cap_col_q[i] != i%6) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_vld = 1'b0;
    repeat (3) tick();
    tests++;
    if (cnt !== 7'd0 || busy !== 1'b0 || in_rdy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: cnt=%0d busy=%0b in_rdy=%0b done=%0b, want 0 0 0 0", cnt, busy, in_rdy, done);
    end
    tests++;
    if (out_row !== 3'd0 || out_col !== 3'd0 || out_num !== 6'd0) begin
      fails++;
      $display("FAIL reset_idx: row=%0d col=%0d num=%0d, want 0 0 0", out_row, out_col, out_num);
    end
    rst = 1'b0;
    repeat (2) tick();
    tests++;
    if (busy !== 1'b0 || cap_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%0b cap_en=%0b, want 0 0", busy, cap_en);
    end
  endtask

  task automatic test_continuous;
    begin_frame();
    tests++;
    if (in_rdy !== 1'b1 || cnt !== 7'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL feed_entry: in_rdy=%0b cnt=%0d busy=%0b, want 1 0 1", in_rdy, cnt, busy);
    end
    wait_done(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cont_timeout: done seen=%0d, want 1", done_cnt);
    end
    tests++;
    if (cap_seq_errs() != 0) begin
      fails++;
      $display("FAIL cont_caps: %0d captures, %0d seq errors, want 36 and 0", cap_cnt_q.size(), cap_seq_errs());
    end
    tests++;
    if (rdy_cnt != 64) begin
      fails++;
      $display("FAIL cont_in_rdy: %0d cycles, want 64", rdy_cnt);
    end
    tests++;
    if (done_cnt != 1 || done_cyc - p != 69 || done_cntval != 68 || done_num != 36) begin
      fails++;
      $display("FAIL cont_done: pulses=%0d at +%0d cnt=%0d num=%0d, want 1 +69 68 36", done_cnt, done_cyc - p, done_cntval, done_num);
    end
    tests++;
    if (busy !== 1'b0 || cnt !== 7'd0 || stray_cap != 0) begin
      fails++;
      $display("FAIL cont_after: busy=%0b cnt=%0d stray=%0d, want 0 0 0", busy, cnt, stray_cap);
    end
  endtask

  task automatic test_stall;
    int stall_bad;
    begin_frame();
    wait_cnt(22, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_reach: cnt=%0d, want 22", cnt);
    end
    stall_bad = 0;
    repeat (3) begin
      in_vld = 1'b0;
      #1;
      if (cnt !== 7'd22 || cap_en !== 1'b0 || step !== 1'b0) stall_bad++;
      tick();
    end
    tests++;
    if (stall_bad != 0 || cnt !== 7'd22) begin
      fails++;
      $display("FAIL stall_hold: bad cycles=%0d cnt=%0d, want 0 22", stall_bad, cnt);
    end
    in_vld = 1'b1;
    #1;
    tests++;
    if (cap_en !== 1'b1 || out_row !== 3'd0 || out_col !== 3'd2) begin
      fails++;
      $display("FAIL stall_resume: cap_en=%0b row=%0d col=%0d, want 1 0 2", cap_en, out_row, out_col);
    end
    wait_done(ok);
    tests++;
    if (!ok || cap_seq_errs() != 0 || done_cyc - p != 72 || done_num != 36) begin
      fails++;
      $display("FAIL stall_frame: caps=%0d errs=%0d done at +%0d num=%0d, want 36 0 +72 36", cap_cnt_q.size(), cap_seq_errs(), done_cyc - p, done_num);
    end
  endtask

  task automatic test_abort;
    begin_frame();
    wait_cnt(30, ok);
    abort = 1'b1;
    #1;
    tests++;
    if (!ok || cap_en !== 1'b0 || step !== 1'b0) begin
      fails++;
      $display("FAIL abort_gate: reached=%0b cap_en=%0b step=%0b, want 1 0 0", ok, cap_en, step);
    end
    tick();
    abort = 1'b0;
    // captures at cnt 20-25 and 28-29 completed before the abort
    tests++;
    if (busy !== 1'b0 || cnt !== 7'd0 || out_num !== 6'd8 || cap_cnt_q.size() != 8) begin
      fails++;
      $display("FAIL abort_state: busy=%0b cnt=%0d num=%0d caps=%0d, want 0 0 8 8", busy, cnt, out_num, cap_cnt_q.size());
    end
    repeat (5) tick();
    tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_nodone: done pulses=%0d busy=%0b, want 0 0", done_cnt, busy);
    end
    begin_frame();
    wait_done(ok);
    tests++;
    if (!ok || cap_seq_errs() != 0 || done_cnt != 1 || done_num != 36) begin
      fails++;
      $display("FAIL abort_refresh: caps=%0d errs=%0d done=%0d num=%0d, want 36 0 1 36", cap_cnt_q.size(), cap_seq_errs(), done_cnt, done_num);
    end
  endtask

  task automatic test_start_ignored;
    begin_frame();
    wait_cnt(40, ok);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (!ok || cnt !== 7'd41 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_mid: cnt=%0d busy=%0b, want 41 1", cnt, busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!ok || cnt !== 7'd68) begin
      fails++;
      $display("FAIL start_reach_done: done=%0b cnt=%0d, want 1 68", done, cnt);
    end
    start = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || cnt !== 7'd0) begin
      fails++;
      $display("FAIL start_in_done: busy=%0b cnt=%0d, want 0 0", busy, cnt);
    end
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_rdy !== 1'b1 || cnt !== 7'd0) begin
      fails++;
      $display("FAIL start_after_done: busy=%0b in_rdy=%0b cnt=%0d, want 1 1 0", busy, in_rdy, cnt);
    end
    tests++;
    if (done_cnt != 1 || done_cyc - p != 69 || cap_seq_errs() != 0) begin
      fails++;
      $display("FAIL start_frame: done=%0d at +%0d errs=%0d, want 1 +69 0", done_cnt, done_cyc - p, cap_seq_errs());
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset;
    int idle_bad;
    begin_frame();
    wait_cnt(66, ok);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (!ok || cnt !== 7'd0 || busy !== 1'b0 || in_rdy !== 1'b0 || done !== 1'b0 ||
        out_num !== 6'd0 || cap_en !== 1'b0 || step !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: cnt=%0d busy=%0b rdy=%0b done=%0b num=%0d cap=%0b step=%0b, want all 0",
               cnt, busy, in_rdy, done, out_num, cap_en, step);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    repeat (4) begin
      tick();
      if (busy !== 1'b0 || cnt !== 7'd0) idle_bad++;
    end
    tests++;
    if (idle_bad != 0 || done_cnt != 0) begin
      fails++;
      $display("FAIL async_idle: bad cycles=%0d done pulses=%0d, want 0 0", idle_bad, done_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || cnt !== 7'd0) begin
      fails++;
      $display("FAIL async_restart: busy=%0b cnt=%0d, want 1 0", busy, cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_back_to_back;
    clear_mon();
    start  = 1'b1;
    in_vld = 1'b1;
    tick();
    p = cyc_n;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done_cnt >= 2) break;
    end
    start = 1'b0;
    tests++;
    if (done_cnt != 2) begin
      fails++;
      $display("FAIL b2b_done_count: %0d, want 2", done_cnt);
    end else begin
      tests++;
      if (done_caps_q[0] != 36 || done_caps_q[1] != 72) begin
        fails++;
        $display("FAIL b2b_caps: %0d then %0d, want 36 then 72", done_caps_q[0], done_caps_q[1]);
      end
      tests++;
      if (done_cyc_q[0] - p != 69 || done_cyc_q[1] - done_cyc_q[0] != 71) begin
        fails++;
        $display("FAIL b2b_timing: first +%0d gap %0d, want +69 71", done_cyc_q[0] - p, done_cyc_q[1] - done_cyc_q[0]);
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: busy=%0b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
